apb_trans_scheduler: RTL and testbench

- Sequences AXI-side write and read bursts onto the single-beat command interface of the APB protocol handler.
- Arbitrates round-robin between one write requester and one read requester.
- Splits each burst into single APB beats, issuing addresses in increments of 4.
- Streams write data in, returns read data out, and aggregates slave errors into responses.

---
 rtl/apb_trans_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_apb_trans_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_trans_scheduler.sv
// Burst-to-beat scheduler in front of the APB protocol handler: round-robin
// arbitration between one write and one read requester, one command in flight.
module apb_trans_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [LEN_WIDTH-1:0]  wr_len_i,
  output logic                  wr_gnt_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic                  wr_resp_valid_o,
  output logic                  wr_resp_err_o,
  input  logic                  wr_resp_ready_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [LEN_WIDTH-1:0]  rd_len_i,
  output logic                  rd_gnt_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_err_o,
  output logic                  rdata_last_o,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic                  wr_trans_o,
  output logic                  rd_trans_o,
  output logic [ADDR_WIDTH-1:0] trans_addr_o,
  output logic [DATA_WIDTH-1:0] trans_data_o,
  output logic [3:0]            burst_len_o,
  input  logic                  trans_done_i,
  input  logic                  trans_error_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RDATA, WRESP} state_e;

  state_e                state_q, state_d;
  logic                  cur_wr_q, cur_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  err_acc_q, err_acc_d;
  logic                  last_was_wr_q, last_was_wr_d;
  logic                  done_q, done_d;
  logic                  wr_gnt_q, wr_gnt_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic                  wr_trans_q, wr_trans_d;
  logic                  rd_trans_q, rd_trans_d;
  logic [ADDR_WIDTH-1:0] trans_addr_q, trans_addr_d;
  logic [DATA_WIDTH-1:0] trans_data_q, trans_data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_err_q, rdata_err_d;
  logic                  rdata_last_q, rdata_last_d;
  logic                  beat_done;

  // Only the rising edge of trans_done_i counts, so a level held high is one beat.
  assign beat_done = trans_done_i && !done_q;

  always_comb begin
    state_d       = state_q;
    cur_wr_d      = cur_wr_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    err_acc_d     = err_acc_q;
    last_was_wr_d = last_was_wr_q;
    done_d        = trans_done_i;
    wr_gnt_d      = 1'b0;
    rd_gnt_d      = 1'b0;
    wr_trans_d    = 1'b0;
    rd_trans_d    = 1'b0;
    trans_addr_d  = trans_addr_q;
    trans_data_d  = trans_data_q;
    rdata_d       = rdata_q;
    rdata_err_d   = rdata_err_q;
    rdata_last_d  = rdata_last_q;

    unique case (state_q)
      IDLE: begin
        if (wr_req_i && (!rd_req_i || !last_was_wr_q)) begin
          cur_wr_d   = 1'b1;
          addr_d     = wr_addr_i;
          len_d      = wr_len_i;
          beat_cnt_d = '0;
          err_acc_d  = 1'b0;
          wr_gnt_d   = 1'b1;
          state_d    = ISSUE;
        end else if (rd_req_i) begin
          cur_wr_d   = 1'b0;
          addr_d     = rd_addr_i;
          len_d      = rd_len_i;
          beat_cnt_d = '0;
          err_acc_d  = 1'b0;
          rd_gnt_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!cur_wr_q) begin
          rd_trans_d   = 1'b1;
          trans_addr_d = addr_q;
          state_d      = WAIT;
        end else if (wdata_valid_i) begin
          wr_trans_d   = 1'b1;
          trans_addr_d = addr_q;
          trans_data_d = wdata_i;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (beat_done) begin
          err_acc_d = err_acc_q | trans_error_i;
          if (!cur_wr_q) begin
            rdata_d      = read_data_i;
            rdata_err_d  = trans_error_i;
            rdata_last_d = (beat_cnt_q == len_q);
            state_d      = RDATA;
          end else if (beat_cnt_q == len_q) begin
            state_d = WRESP;
          end else begin
            addr_d     = addr_q + ADDR_WIDTH'(4);
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            state_d    = ISSUE;
          end
        end
      end
      RDATA: begin
        if (rdata_ready_i) begin
          if (rdata_last_q) begin
            last_was_wr_d = cur_wr_q;
            state_d       = IDLE;
          end else begin
            addr_d     = addr_q + ADDR_WIDTH'(4);
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            state_d    = ISSUE;
          end
        end
      end
      WRESP: begin
        if (wr_resp_ready_i) begin
          last_was_wr_d = cur_wr_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_wr_q      <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      err_acc_q     <= 1'b0;
      last_was_wr_q <= 1'b0;
      done_q        <= 1'b0;
      wr_gnt_q      <= 1'b0;
      rd_gnt_q      <= 1'b0;
      wr_trans_q    <= 1'b0;
      rd_trans_q    <= 1'b0;
      trans_addr_q  <= '0;
      trans_data_q  <= '0;
      rdata_q       <= '0;
      rdata_err_q   <= 1'b0;
      rdata_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_wr_q      <= cur_wr_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      err_acc_q     <= err_acc_d;
      last_was_wr_q <= last_was_wr_d;
      done_q        <= done_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_gnt_q      <= rd_gnt_d;
      wr_trans_q    <= wr_trans_d;
      rd_trans_q    <= rd_trans_d;
      trans_addr_q  <= trans_addr_d;
      trans_data_q  <= trans_data_d;
      rdata_q       <= rdata_d;
      rdata_err_q   <= rdata_err_d;
      rdata_last_q  <= rdata_last_d;
    end
  end

  assign wr_gnt_o        = wr_gnt_q;
  assign rd_gnt_o        = rd_gnt_q;
  assign wdata_ready_o   = (state_q == ISSUE) && cur_wr_q && wdata_valid_i;
  assign wr_resp_valid_o = (state_q == WRESP);
  assign wr_resp_err_o   = err_acc_q;
  assign rdata_o         = rdata_q;
  assign rdata_err_o     = rdata_err_q;
  assign rdata_last_o    = rdata_last_q;
  assign rdata_valid_o   = (state_q == RDATA);
  assign wr_trans_o      = wr_trans_q;
  assign rd_trans_o      = rd_trans_q;
  assign trans_addr_o    = trans_addr_q;
  assign trans_data_o    = trans_data_q;
  assign burst_len_o     = '0;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_apb_trans_scheduler.sv
// Directed bench for apb_trans_scheduler: plays the handler and both requesters.
module tb_apb_trans_scheduler;

  logic        clk;
  logic        rst_n;
  logic        wr_req_i;
  logic [31:0] wr_addr_i;
  logic [3:0]  wr_len_i;
  logic        wr_gnt_o;
  logic [31:0] wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic        wr_resp_valid_o;
  logic        wr_resp_err_o;
  logic        wr_resp_ready_i;
  logic        rd_req_i;
  logic [31:0] rd_addr_i;
  logic [3:0]  rd_len_i;
  logic        rd_gnt_o;
  logic [31:0] rdata_o;
  logic        rdata_err_o;
  logic        rdata_last_o;
  logic        rdata_valid_o;
  logic        rdata_ready_i;
  logic        wr_trans_o;
  logic        rd_trans_o;
  logic [31:0] trans_addr_o;
  logic [31:0] trans_data_o;
  logic [3:0]  burst_len_o;
  logic        trans_done_i;
  logic        trans_error_i;
  logic [31:0] read_data_i;
  logic        busy_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cnt_wtrans = 0;
  int unsigned cnt_rtrans = 0;
  int unsigned cnt_wready = 0;

  logic [110:0] all_outs;
  assign all_outs = {wr_gnt_o, wdata_ready_o, wr_resp_valid_o, wr_resp_err_o, rd_gnt_o,
                     rdata_o, rdata_err_o, rdata_last_o, rdata_valid_o, wr_trans_o,
                     rd_trans_o, trans_addr_o, trans_data_o, burst_len_o, busy_o};

  apb_trans_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i), .wr_gnt_o(wr_gnt_o),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wr_resp_valid_o(wr_resp_valid_o), .wr_resp_err_o(wr_resp_err_o),
    .wr_resp_ready_i(wr_resp_ready_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i), .rd_gnt_o(rd_gnt_o),
    .rdata_o(rdata_o), .rdata_err_o(rdata_err_o), .rdata_last_o(rdata_last_o),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .wr_trans_o(wr_trans_o), .rd_trans_o(rd_trans_o), .trans_addr_o(trans_addr_o),
    .trans_data_o(trans_data_o), .burst_len_o(burst_len_o),
    .trans_done_i(trans_done_i), .trans_error_i(trans_error_i),
    .read_data_i(read_data_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_trans_o) cnt_wtrans++;
      if (rd_trans_o) cnt_rtrans++;
      if (wdata_ready_o) cnt_wready++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_write_beat(input logic [31:0] ea, input logic [31:0] d,
                               input logic err, input int unsigned dly);
    wdata_valid_i = 1'b0;
    #1;
    for (int unsigned k = 0; k < dly; k++) begin
      n_cmp++;
      if ({wr_trans_o, wdata_ready_o} !== 2'b00) begin
        n_err++;
        $display("FAIL wdata_stall: trans/ready=%b required 00", {wr_trans_o, wdata_ready_o});
      end
      step();
    end
    wdata_i = d;
    wdata_valid_i = 1'b1;
    #1;
    for (int k = 0; k < 20 && wdata_ready_o !== 1'b1; k++) step();
    n_cmp++;
    if (wdata_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL wdata_ready_wait: ready=%b required 1", wdata_ready_o);
    end
    step();
    wdata_valid_i = 1'b0;
    n_cmp++;
    if ({wr_trans_o, trans_addr_o, trans_data_o} !== {1'b1, ea, d}) begin
      n_err++;
      $display("FAIL wr_beat: trans=%b addr=%h data=%h required 1 %h %h",
               wr_trans_o, trans_addr_o, trans_data_o, ea, d);
    end
    trans_done_i = 1'b1;
    trans_error_i = err;
    step();
    trans_done_i = 1'b0;
    trans_error_i = 1'b0;
  endtask

  task automatic do_read_beat(input logic [31:0] ea, input logic [31:0] d,
                              input logic err, input int unsigned stall, input logic last);
    for (int k = 0; k < 20 && rd_trans_o !== 1'b1; k++) step();
    n_cmp++;
    if ({rd_trans_o, trans_addr_o} !== {1'b1, ea}) begin
      n_err++;
      $display("FAIL rd_beat: trans=%b addr=%h required 1 %h", rd_trans_o, trans_addr_o, ea);
    end
    trans_done_i = 1'b1;
    trans_error_i = err;
    read_data_i = d;
    step();
    trans_done_i = 1'b0;
    trans_error_i = 1'b0;
    n_cmp++;
    if ({rdata_valid_o, rdata_o, rdata_err_o, rdata_last_o} !== {1'b1, d, err, last}) begin
      n_err++;
      $display("FAIL rdata: valid=%b data=%h err=%b last=%b required 1 %h %b %b",
               rdata_valid_o, rdata_o, rdata_err_o, rdata_last_o, d, err, last);
    end
    rdata_ready_i = 1'b0;
    for (int unsigned k = 0; k < stall; k++) begin
      step();
      n_cmp++;
      if ({rdata_valid_o, rdata_o, rdata_last_o, rd_trans_o} !== {1'b1, d, last, 1'b0}) begin
        n_err++;
        $display("FAIL rdata_stall: valid=%b data=%h last=%b rd_trans=%b required 1 %h %b 0",
                 rdata_valid_o, rdata_o, rdata_last_o, rd_trans_o, d, last);
      end
    end
    rdata_ready_i = 1'b1;
    step();
    rdata_ready_i = 1'b0;
  endtask

  task automatic write_resp(input logic exp_err);
    n_cmp++;
    if ({wr_resp_valid_o, wr_resp_err_o, busy_o} !== {1'b1, exp_err, 1'b1}) begin
      n_err++;
      $display("FAIL wr_resp: valid=%b err=%b busy=%b required 1 %b 1",
               wr_resp_valid_o, wr_resp_err_o, busy_o, exp_err);
    end
    wr_resp_ready_i = 1'b1;
    step();
    wr_resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    wr_req_i = 1'b1;
    rd_req_i = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: outs=%h required 0", all_outs);
    end
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy_o, wr_gnt_o, rd_gnt_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: busy/gnts=%b required 000", {busy_o, wr_gnt_o, rd_gnt_o});
    end
  endtask

  task automatic test_single_write();
    wr_addr_i = 32'h0001_F000;
    wr_len_i = 4'd0;
    wdata_i = 32'hA5A5_A5A5;
    wdata_valid_i = 1'b1;
    wr_req_i = 1'b1;
    step();
    n_cmp++;
    if ({wr_gnt_o, rd_gnt_o, busy_o} !== 3'b101) begin
      n_err++;
      $display("FAIL single_gnt: wr/rd/busy=%b required 101", {wr_gnt_o, rd_gnt_o, busy_o});
    end
    wr_req_i = 1'b0;
    do_write_beat(32'h0001_F000, 32'hA5A5_A5A5, 1'b0, 0);
    write_resp(1'b0);
    n_cmp++;
    if ({busy_o, burst_len_o} !== 5'b0) begin
      n_err++;
      $display("FAIL single_idle: busy=%b burst_len=%h required 0 0", busy_o, burst_len_o);
    end
  endtask

  task automatic test_read_stall();
    int unsigned r0;
    r0 = cnt_rtrans;
    rd_addr_i = 32'h0002_F000;
    rd_len_i = 4'd3;
    rd_req_i = 1'b1;
    for (int k = 0; k < 20 && rd_gnt_o !== 1'b1; k++) step();
    n_cmp++;
    if ({rd_gnt_o, wr_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL read_gnt: rd/wr=%b required 10", {rd_gnt_o, wr_gnt_o});
    end
    rd_req_i = 1'b0;
    do_read_beat(32'h0002_F000, 32'h1111_0000, 1'b0, 0, 1'b0);
    do_read_beat(32'h0002_F004, 32'h2222_0001, 1'b0, 2, 1'b0);
    do_read_beat(32'h0002_F008, 32'h3333_0002, 1'b1, 0, 1'b0);
    do_read_beat(32'h0002_F00C, 32'h4444_0003, 1'b0, 0, 1'b1);
    n_cmp++;
    if (busy_o !== 1'b0 || cnt_rtrans - r0 != 4) begin
      n_err++;
      $display("FAIL read_end: busy=%b rd_trans_count=%0d required 0 4", busy_o, cnt_rtrans - r0);
    end
  endtask

  task automatic test_round_robin();
    logic exp_w;
    apply_reset();
    wr_addr_i = 32'h0000_1000;
    wr_len_i = 4'd0;
    rd_addr_i = 32'h0000_2000;
    rd_len_i = 4'd0;
    wr_req_i = 1'b1;
    rd_req_i = 1'b1;
    for (int unsigned g = 0; g < 4; g++) begin
      exp_w = (g % 2 == 0);
      for (int k = 0; k < 20 && wr_gnt_o !== 1'b1 && rd_gnt_o !== 1'b1; k++) step();
      n_cmp++;
      if ({wr_gnt_o, rd_gnt_o} !== {exp_w, !exp_w}) begin
        n_err++;
        $display("FAIL rr_grant%0d: wr/rd=%b required %b", g, {wr_gnt_o, rd_gnt_o}, {exp_w, !exp_w});
      end
      if (g == 3) wr_req_i = 1'b0;
      if (wr_gnt_o) begin
        wr_req_i = 1'b0;
        do_write_beat(32'h0000_1000, 32'h0BAD_0000 + g, 1'b0, 0);
        write_resp(1'b0);
        if (g < 3) wr_req_i = 1'b1;
      end else if (rd_gnt_o) begin
        rd_req_i = 1'b0;
        do_read_beat(32'h0000_2000, 32'h0000_0F00 + g, 1'b0, 0, 1'b1);
        if (g < 3) rd_req_i = 1'b1;
      end
    end
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    step();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL rr_idle: busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_write_error();
    int unsigned w0;
    w0 = cnt_wtrans;
    wr_addr_i = 32'h0003_0000;
    wr_len_i = 4'd3;
    wr_req_i = 1'b1;
    for (int k = 0; k < 20 && wr_gnt_o !== 1'b1; k++) step();
    wr_req_i = 1'b0;
    for (int unsigned b = 0; b < 4; b++)
      do_write_beat(32'h0003_0000 + 4 * b, 32'h0000_0100 + b, (b == 2), 0);
    n_cmp++;
    if (cnt_wtrans - w0 != 4) begin
      n_err++;
      $display("FAIL werr_beats: wr_trans_count=%0d required 4", cnt_wtrans - w0);
    end
    write_resp(1'b1);
  endtask

  task automatic test_write_wrap();
    int unsigned w0, r0;
    w0 = cnt_wtrans;
    r0 = cnt_wready;
    wr_addr_i = 32'hFFFF_FFFC;
    wr_len_i = 4'd1;
    wr_req_i = 1'b1;
    for (int k = 0; k < 20 && wr_gnt_o !== 1'b1; k++) step();
    wr_req_i = 1'b0;
    do_write_beat(32'hFFFF_FFFC, 32'hDEAD_0000, 1'b0, 0);
    do_write_beat(32'h0000_0000, 32'hDEAD_0001, 1'b0, 3);
    write_resp(1'b0);
    n_cmp++;
    if (cnt_wready - r0 != 2 || cnt_wtrans - w0 != 2) begin
      n_err++;
      $display("FAIL wrap_counts: wready=%0d wr_trans=%0d required 2 2",
               cnt_wready - r0, cnt_wtrans - w0);
    end
  endtask

  task automatic test_reset_midburst();
    rd_addr_i = 32'h0004_0000;
    rd_len_i = 4'd3;
    rd_req_i = 1'b1;
    for (int k = 0; k < 20 && rd_gnt_o !== 1'b1; k++) step();
    rd_req_i = 1'b0;
    do_read_beat(32'h0004_0000, 32'h5555_0000, 1'b0, 0, 1'b0);
    do_read_beat(32'h0004_0004, 32'h5555_0001, 1'b0, 0, 1'b0);
    for (int k = 0; k < 20 && rd_trans_o !== 1'b1; k++) step();
    n_cmp++;
    if ({rd_trans_o, trans_addr_o} !== {1'b1, 32'h0004_0008}) begin
      n_err++;
      $display("FAIL mid_beat2: trans=%b addr=%h required 1 00040008", rd_trans_o, trans_addr_o);
    end
    trans_done_i = 1'b1;
    read_data_i = 32'h5555_0002;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: outs=%h required 0", all_outs);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy_o, rdata_valid_o, wr_resp_valid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_stale_done: busy/rvalid/wresp=%b required 000",
               {busy_o, rdata_valid_o, wr_resp_valid_o});
    end
    trans_done_i = 1'b0;
    step();
    rd_addr_i = 32'h0005_0010;
    rd_len_i = 4'd0;
    rd_req_i = 1'b1;
    for (int k = 0; k < 20 && rd_gnt_o !== 1'b1; k++) step();
    rd_req_i = 1'b0;
    do_read_beat(32'h0005_0010, 32'hCAFE_F00D, 1'b0, 0, 1'b1);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_fresh_end: busy=%b required 0", busy_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_req_i = 1'b0;
    wr_addr_i = '0;
    wr_len_i = '0;
    wdata_i = '0;
    wdata_valid_i = 1'b0;
    wr_resp_ready_i = 1'b0;
    rd_req_i = 1'b0;
    rd_addr_i = '0;
    rd_len_i = '0;
    rdata_ready_i = 1'b0;
    trans_done_i = 1'b0;
    trans_error_i = 1'b0;
    read_data_i = '0;
    test_reset();
    test_single_write();
    test_read_stall();
    test_round_robin();
    test_write_error();
    test_write_wrap();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
